// File: rtl/ioport2_msg_reg_master.sv
// ioport2 message register master.
//
// Executes 64-bit ioport2 request messages ({ctrl[31:0], data[31:0]}) on a local
// single-cycle register port and returns read results as ioport2 response messages.
// One transaction is in flight at a time. A bounded ack timeout keeps a dead
// register slave from stalling the message path.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   msgi_tdata/tvalid/tready          inbound request stream
//   msgo_tdata/tvalid/tready          outbound read-response stream
//   reg_wr_stb, reg_rd_stb            one-cycle access strobes
//   reg_addr, reg_wr_data             latched address / write data
//   reg_rd_data, reg_ack              slave read data and completion
//   busy                              high whenever not idle
//   err_count                         saturating count of timeouts and dropped messages
module ioport2_msg_reg_master #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       msgi_tdata,
  input  logic              msgi_tvalid,
  output logic              msgi_tready,
  output logic [63:0]       msgo_tdata,
  output logic              msgo_tvalid,
  input  logic              msgo_tready,
  output logic              reg_wr_stb,
  output logic              reg_rd_stb,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wr_data,
  input  logic [31:0]       reg_rd_data,
  input  logic              reg_ack,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int unsigned PadW = 29 - ADDR_W;
  // Counter value in the last wait cycle; the counter reaches all-ones at its end.
  localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  typedef enum logic [1:0] {StIdle, StStrobe, StWait, StResp} state_e;

  state_e               state_q;
  logic                 is_rd_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;

  logic [31:0] ctrl;
  logic        accept;
  logic        req_ok;
  logic        drop;
  logic        timeout;
  logic        done;
  logic [31:0] rsp_data;
  logic        unused_ctrl;

  assign ctrl     = msgi_tdata[63:32];
  assign accept   = msgi_tvalid & msgi_tready;
  // Exactly one of wr_request / rd_request, and no rd_response bit.
  assign req_ok   = ~ctrl[31] & (ctrl[30] ^ ctrl[29]);
  assign drop     = accept & ~req_ok;
  // Ack wins over a coincident timeout.
  assign timeout  = (state_q == StWait) & ~reg_ack & (tmo_cnt_q == TmoLast);
  assign done     = ((state_q == StStrobe) | (state_q == StWait)) & (reg_ack | timeout);
  assign rsp_data = reg_ack ? reg_rd_data : 32'hFFFF_FFFF;

  assign unused_ctrl = ^msgi_tdata[60:32+ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      is_rd_q     <= 1'b0;
      tmo_cnt_q   <= '0;
      msgi_tready <= 1'b0;
      msgo_tvalid <= 1'b0;
      msgo_tdata  <= '0;
      reg_wr_stb  <= 1'b0;
      reg_rd_stb  <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      busy        <= 1'b0;
      err_count   <= '0;
    end else begin
      reg_wr_stb <= 1'b0;
      reg_rd_stb <= 1'b0;

      // Drops only happen in idle and timeouts only in wait, so at most one per cycle.
      if ((drop || timeout) && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          // Also raises ready on the first edge after reset release.
          msgi_tready <= 1'b1;
          if (accept && req_ok) begin
            reg_addr    <= ctrl[ADDR_W-1:0];
            reg_wr_data <= msgi_tdata[31:0];
            is_rd_q     <= ctrl[29];
            reg_wr_stb  <= ctrl[30];
            reg_rd_stb  <= ctrl[29];
            tmo_cnt_q   <= '0;
            msgi_tready <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StStrobe;
          end
        end

        StStrobe, StWait: begin
          if (state_q == StWait) begin
            tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
          end
          if (done) begin
            if (is_rd_q) begin
              msgo_tvalid <= 1'b1;
              msgo_tdata  <= {1'b1, 2'b00, {PadW{1'b0}}, reg_addr, rsp_data};
              state_q     <= StResp;
            end else begin
              msgi_tready <= 1'b1;
              busy        <= 1'b0;
              state_q     <= StIdle;
            end
          end else begin
            state_q <= StWait;
          end
        end

        StResp: begin
          if (msgo_tready) begin
            msgo_tvalid <= 1'b0;
            msgo_tdata  <= '0;
            msgi_tready <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ioport2_msg_reg_master.sv
module tb_ioport2_msg_reg_master;

  localparam int unsigned AW = 20;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   msgi_tdata = '0;
  logic          msgi_tvalid = 1'b0;
  logic          msgi_tready;
  logic [63:0]   msgo_tdata;
  logic          msgo_tvalid;
  logic          msgo_tready = 1'b0;
  logic          reg_wr_stb;
  logic          reg_rd_stb;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wr_data;
  logic [31:0]   reg_rd_data = '0;
  logic          reg_ack = 1'b0;
  logic          busy;
  logic [7:0]    err_count;

  ioport2_msg_reg_master #(.ADDR_W(AW), .TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .msgi_tdata  (msgi_tdata),
    .msgi_tvalid (msgi_tvalid),
    .msgi_tready (msgi_tready),
    .msgo_tdata  (msgo_tdata),
    .msgo_tvalid (msgo_tvalid),
    .msgo_tready (msgo_tready),
    .reg_wr_stb  (reg_wr_stb),
    .reg_rd_stb  (reg_rd_stb),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data),
    .reg_ack     (reg_ack),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          rd;
    logic [19:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_req[$];
  logic [63:0] exp_rsp[$];
  int          err_model = 0;

  function automatic bit is_good(input logic [31:0] c);
    int n;
    n = int'(c[31]) + int'(c[30]) + int'(c[29]);
    return (n == 1) && !c[31];
  endfunction

  function automatic logic [63:0] rsp_word(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] hdr;
    hdr = 32'h8000_0000 + (c & 32'h000F_FFFF);
    return {hdr, d};
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // ---------------- register slave ----------------
  int          ack_dly  = -1;
  logic [31:0] ack_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (reg_wr_stb || reg_rd_stb) && ack_dly >= 0) begin
        repeat (ack_dly) @(negedge clk);
        reg_ack     = 1'b1;
        reg_rd_data = ack_data;
        @(negedge clk);
        reg_ack = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        prev_stb = 1'b0;
  logic        prev_vld = 1'b0;
  logic [63:0] prev_dat = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (reg_wr_stb || reg_rd_stb) begin
          chk("single_strobe", {63'd0, reg_wr_stb & reg_rd_stb}, 64'd0);
          chk("strobe_width", {63'd0, prev_stb}, 64'd0);
          chk("strobe_expected", {63'd0, exp_req.size() > 0}, 64'd1);
          if (exp_req.size() > 0) begin
            chk("strobe_type", {63'd0, reg_rd_stb}, {63'd0, exp_req[0].rd});
            chk("strobe_addr", 64'(reg_addr), 64'(exp_req[0].addr));
            chk("strobe_data", 64'(reg_wr_data), 64'(exp_req[0].data));
            void'(exp_req.pop_front());
          end
        end
        if (msgo_tvalid) begin
          chk("rsp_expected", {63'd0, exp_rsp.size() > 0}, 64'd1);
          if (exp_rsp.size() > 0) chk("rsp_data", msgo_tdata, exp_rsp[0]);
          if (prev_vld) chk("rsp_stable", msgo_tdata, prev_dat);
          if (msgo_tready && exp_rsp.size() > 0) void'(exp_rsp.pop_front());
        end
        prev_stb = reg_wr_stb | reg_rd_stb;
        prev_vld = msgo_tvalid & ~msgo_tready;
        prev_dat = msgo_tdata;
      end else begin
        prev_stb = 1'b0;
        prev_vld = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the handshake cycle.
  task automatic send(input logic [31:0] c, input logic [31:0] d, output int t_acc);
    bit ok;
    ok = 1'b0;
    t_acc = -1;
    if (is_good(c)) begin
      req_t r;
      r.rd   = c[29];
      r.addr = c[19:0];
      r.data = d;
      exp_req.push_back(r);
    end else begin
      err_model = sat_add(err_model, 1);
    end
    msgi_tdata  = {c, d};
    msgi_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (msgi_tready) begin
        ok = 1'b1;
        t_acc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", {63'd0, ok}, 64'd1);
    @(negedge clk);
    msgi_tvalid = 1'b0;
  endtask

  task automatic wait_rsp(output int t_v);
    t_v = -1;
    for (int i = 0; i < 60; i++) begin
      if (msgo_tvalid) begin
        t_v = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_arrived", {63'd0, t_v >= 0}, 64'd1);
  endtask

  initial begin
    int t;
    int tv;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tv;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tready", {63'd0, msgi_tready}, 64'd0);
    chk("rst_tvalid", {63'd0, msgo_tvalid}, 64'd0);
    chk("rst_tdata", msgo_tdata, 64'd0);
    chk("rst_strobes", {62'd0, reg_wr_stb, reg_rd_stb}, 64'd0);
    chk("rst_addr", 64'(reg_addr), 64'd0);
    chk("rst_wdata", 64'(reg_wr_data), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tready", {63'd0, msgi_tready}, 64'd1);

    // Write, ack in strobe cycle
    ack_dly = 0;
    send(32'h4000_0010, 32'hCAFE_0001, t);
    chk("wr_strobe_cycle", 64'(cyc), 64'(t + 1));
    chk("wr_strobe_lit", {63'd0, reg_wr_stb}, 64'd1);
    chk("wr_addr_lit", 64'(reg_addr), 64'h10);
    chk("wr_data_lit", 64'(reg_wr_data), 64'hCAFE_0001);
    chk("wr_tready_low", {63'd0, msgi_tready}, 64'd0);
    chk("wr_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("wr_tready_back", {63'd0, msgi_tready}, 64'd1);
    chk("wr_busy_clr", {63'd0, busy}, 64'd0);
    chk("wr_addr_hold", 64'(reg_addr), 64'h10);
    chk("wr_data_hold", 64'(reg_wr_data), 64'hCAFE_0001);
    repeat (3) @(negedge clk);

    // Read, ack 3 cycles after strobe, response held under back-pressure
    ack_dly  = 3;
    ack_data = 32'h1234_5678;
    msgo_tready = 1'b0;
    exp_rsp.push_back(rsp_word(32'h2000_0024, 32'h1234_5678));
    send(32'h2000_0024, 32'h0, t);
    wait_rsp(tv);
    chk("rd_rsp_cycle", 64'(tv), 64'(t + 5));
    chk("rd_rsp_lit", msgo_tdata, 64'h8000_0024_1234_5678);
    repeat (5) @(negedge clk);
    chk("rd_rsp_held", msgo_tdata, 64'h8000_0024_1234_5678);
    chk("rd_busy", {63'd0, busy}, 64'd1);
    msgo_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rd_rsp_done", {63'd0, msgo_tvalid}, 64'd0);
    chk("rd_rsp_consumed", 64'(exp_rsp.size()), 64'd0);

    // Read timeout
    ack_dly = -1;
    exp_rsp.push_back(rsp_word(32'h2000_0003, 32'hFFFF_FFFF));
    send(32'h2000_0003, 32'h0, t);
    wait_rsp(tv);
    err_model = sat_add(err_model, 1);
    chk("tmo_rsp_cycle", 64'(tv), 64'(t + 1 + (1 << TW)));
    chk("tmo_rsp_lit", msgo_tdata, 64'h8000_0003_FFFF_FFFF);
    chk("tmo_err", 64'(err_count), 64'(err_model));
    chk("tmo_err_lit", 64'(err_count), 64'd1);
    repeat (2) @(negedge clk);

    // Two bad messages in consecutive cycles
    msgi_tdata  = {32'h8000_0000, 32'h0};
    msgi_tvalid = 1'b1;
    chk("bad1_tready", {63'd0, msgi_tready}, 64'd1);
    @(negedge clk);
    msgi_tdata = {32'h6000_0000, 32'h0};
    chk("bad2_tready", {63'd0, msgi_tready}, 64'd1);
    @(negedge clk);
    msgi_tvalid = 1'b0;
    err_model = sat_add(err_model, 2);
    chk("bad_err", 64'(err_count), 64'(err_model));
    chk("bad_err_lit", 64'(err_count), 64'd3);
    chk("bad_busy", {63'd0, busy}, 64'd0);

    // 300 consecutive bad messages saturate the counter
    msgi_tdata  = 64'd0;
    msgi_tvalid = 1'b1;
    repeat (300) @(negedge clk);
    msgi_tvalid = 1'b0;
    err_model = sat_add(err_model, 300);
    @(negedge clk);
    chk("sat_err", 64'(err_count), 64'(err_model));
    chk("sat_err_lit", 64'(err_count), 64'hFF);

    // Reset while a response is pending
    ack_dly = 0;
    ack_data = 32'hA5A5_0000;
    msgo_tready = 1'b0;
    exp_rsp.push_back(rsp_word(32'h2000_0008, 32'hA5A5_0000));
    send(32'h2000_0008, 32'h0, t);
    wait_rsp(tv);
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {63'd0, msgo_tvalid}, 64'd0);
    chk("arst_tdata", msgo_tdata, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_err", 64'(err_count), 64'd0);
    exp_rsp.delete();
    exp_req.delete();
    err_model = 0;
    ack_dly = -1;
    @(negedge clk);
    rst_n = 1'b1;
    msgo_tready = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_tvalid", {63'd0, msgo_tvalid}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_tready", {63'd0, msgi_tready}, 64'd1);
    chk("post_rst_err", 64'(err_count), 64'(err_model));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
